// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory FSM states, access
// size and direction encodings, byte-lane helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

    // Lane i holds the byte at word offset i (big-endian: lane 0 is [31:24]).
    function automatic logic [3:0] byte_lane_we(input logic [1:0] off);
        return 4'b0001 << off;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-addressed data memory: four byte-lane write enables,
// synchronous write, combinational big-endian word read.
module dmem_array #(
    parameter int DEPTH_BYTES = 256
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_BYTES)-3:0] word_addr_i,
    input  logic [3:0]                     we_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [7:0] mem_q [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[{word_addr_i, 2'(i)}] <= wdata_i[31-8*i -: 8];
            end
        end
    end

    assign rdata_o = {mem_q[{word_addr_i, 2'd0}],
                      mem_q[{word_addr_i, 2'd1}],
                      mem_q[{word_addr_i, 2'd2}],
                      mem_q[{word_addr_i, 2'd3}]};

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: latches a request, inserts
// wait states, then performs the access in a single RESP cycle.
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        readwrite,
    input  logic        size,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e    state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           rw_q, rw_d;
    logic           size_q, size_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    data_out_q, data_out_d;

    logic           go_resp;
    logic           acc_rw;
    logic           acc_size;
    logic [AW-1:0]  acc_addr;
    logic [31:0]    acc_wdata;
    logic [1:0]     off;
    logic [3:0]     mem_we;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata;
    logic [7:0]     rbyte;
    logic           unused_addr;

    assign unused_addr = ^addr[31:AW];

    // With no wait states the access happens on the accepting edge,
    // so the live inputs stand in for the not-yet-latched copies.
    assign acc_rw    = (state_q == ST_IDLE) ? readwrite     : rw_q;
    assign acc_size  = (state_q == ST_IDLE) ? size          : size_q;
    assign acc_addr  = (state_q == ST_IDLE) ? addr[AW-1:0]  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? data_in       : wdata_q;
    assign off       = acc_addr[1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        go_resp    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    rw_d    = readwrite;
                    size_d  = size;
                    addr_d  = addr[AW-1:0];
                    wdata_d = data_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rbyte = mem_rdata[31:24];
        unique case (off)
            2'd0: rbyte = mem_rdata[31:24];
            2'd1: rbyte = mem_rdata[23:16];
            2'd2: rbyte = mem_rdata[15:8];
            2'd3: rbyte = mem_rdata[7:0];
        endcase
    end

    always_comb begin
        mem_we     = 4'b0000;
        mem_wdata  = acc_wdata;
        data_out_d = data_out_q;
        if (acc_size == SIZE_BYTE) begin
            mem_wdata = {4{acc_wdata[7:0]}};
        end
        if (go_resp && !reset) begin
            if (acc_rw == RW_WRITE) begin
                mem_we = (acc_size == SIZE_WORD) ? 4'hF : byte_lane_we(off);
            end else begin
                data_out_d = (acc_size == SIZE_WORD) ? mem_rdata
                                                     : {24'd0, rbyte};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            data_out_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        rw_q    <= rw_d;
        size_q  <= size_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    dmem_array #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_array (
        .clk         (clk),
        .word_addr_i (acc_addr[AW-1:2]),
        .we_i        (mem_we),
        .wdata_i     (mem_wdata),
        .rdata_o     (mem_rdata)
    );

    assign data_out = data_out_q;
    assign busy     = ((state_q == ST_IDLE) && en) || (state_q == ST_WAIT);
    assign done     = (state_q == ST_RESP);
    assign misalign = (state_q == ST_RESP) && (size_q == SIZE_WORD)
                      && (addr_q[1:0] != 2'b00);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios and random accesses
// against a byte-array memory model, WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        en2, en0;
    logic        readwrite, size;
    logic [31:0] addr, data_in;
    logic [31:0] dout2, dout0;
    logic        busy2, busy0, done2, done0, mis2, mis0;

    int checks = 0;
    int errors = 0;

    // index 1 -> WAIT_CYCLES=2 instance, index 0 -> WAIT_CYCLES=0 instance
    logic [7:0]  mdl [2][256];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .en(en2), .readwrite(readwrite),
        .size(size), .addr(addr), .data_in(data_in), .data_out(dout2),
        .busy(busy2), .done(done2), .misalign(mis2)
    );

    dmem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .en(en0), .readwrite(readwrite),
        .size(size), .addr(addr), .data_in(data_in), .data_out(dout0),
        .busy(busy0), .done(done0), .misalign(mis0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int d, input int a);
        int b;
        b = (a % 256) & 32'hFC;
        return (32'(mdl[d][b]) << 24) + (32'(mdl[d][b+1]) << 16)
             + (32'(mdl[d][b+2]) << 8) + 32'(mdl[d][b+3]);
    endfunction

    task automatic set_en(input int d, input logic v);
        if (d == 1) en2 = v;
        else en0 = v;
    endtask

    task automatic access(input int d, input logic rw, input logic sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got);
        int lat, ba, wc;
        logic dn, bs, ms, exp_mis;
        logic [31:0] dq;
        wc = (d == 1) ? 2 : 0;
        ba = int'(a % 256);
        if (rw) begin
            if (sz) begin
                for (int i = 0; i < 4; i++)
                    mdl[d][(ba & 32'hFC) + i] = 8'(wd >> (24 - 8*i));
            end else begin
                mdl[d][ba] = wd[7:0];
            end
        end else begin
            last_rd[d] = sz ? mword(d, ba) : {24'd0, mdl[d][ba]};
        end
        exp_mis = sz && (a[1:0] != 2'b00);
        @(posedge clk); #1;
        readwrite = rw; size = sz; addr = a; data_in = wd;
        set_en(d, 1'b1);
        lat = 0; dn = 1'b0; bs = 1'b0; ms = 1'b0; dq = '0;
        while (!dn && lat < 40) begin
            @(negedge clk);
            dn = (d == 1) ? done2 : done0;
            bs = (d == 1) ? busy2 : busy0;
            ms = (d == 1) ? mis2  : mis0;
            dq = (d == 1) ? dout2 : dout0;
            if (!dn) begin
                chk("busy_before_done", 32'(bs), 32'd1);
                lat++;
                @(posedge clk); #1;
                addr = $urandom; data_in = $urandom;
                readwrite = 1'($urandom_range(0, 1));
                size = 1'($urandom_range(0, 1));
                set_en(d, 1'($urandom_range(0, 1)));
            end
        end
        chk("done_latency", 32'(lat), 32'(wc + 1));
        if (dn) begin
            chk("busy_in_resp", 32'(bs), 32'd0);
            chk("misalign", 32'(ms), 32'(exp_mis));
            chk("data_out", dq, last_rd[d]);
        end
        got = dq;
        @(posedge clk); #1;
        set_en(d, 1'b0);
    endtask

    initial begin
        logic [31:0] got;
        int ndone;
        reset = 1'b1; en2 = 1'b1; en0 = 1'b0;
        readwrite = 1'b0; size = 1'b0; addr = '0; data_in = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        for (int i = 0; i < 256; i++) begin
            mdl[0][i] = '0; mdl[1][i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dout2", dout2, 32'd0);
        chk("rst_dout0", dout0, 32'd0);
        chk("rst_done2", 32'(done2), 32'd0);
        chk("rst_mis2", 32'(mis2), 32'd0);
        chk("rst_busy2_eq_en", 32'(busy2), 32'd1);
        chk("rst_busy0_eq_en", 32'(busy0), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; en2 = 1'b0;

        access(1, 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, got);
        access(1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, got);
        access(1, 1'b0, 1'b1, 32'h10, 32'h0, got);
        chk("word_rd_10", got, 32'hDEAD_BEEF);
        access(1, 1'b0, 1'b0, 32'h10, 32'h0, got);
        chk("byte_rd_10", got, 32'h0000_00DE);
        access(1, 1'b0, 1'b0, 32'h11, 32'h0, got);
        chk("byte_rd_11", got, 32'h0000_00AD);
        access(1, 1'b0, 1'b0, 32'h12, 32'h0, got);
        chk("byte_rd_12", got, 32'h0000_00BE);
        access(1, 1'b0, 1'b0, 32'h13, 32'h0, got);
        chk("byte_rd_13", got, 32'h0000_00EF);
        access(1, 1'b1, 1'b0, 32'h12, 32'hFFFF_FF55, got);
        chk("dout_held_on_write", got, 32'h0000_00EF);
        access(1, 1'b0, 1'b1, 32'h10, 32'h0, got);
        chk("after_byte_wr", got, 32'hDEAD_55EF);
        access(1, 1'b0, 1'b1, 32'h11, 32'h0, got);
        chk("misaligned_rd", got, 32'hDEAD_55EF);
        access(1, 1'b1, 1'b1, 32'h110, 32'h1234_5678, got);
        access(1, 1'b0, 1'b1, 32'h10, 32'h0, got);
        chk("wrap_rd", got, 32'h1234_5678);

        @(posedge clk); #1;
        readwrite = 1'b1; size = 1'b1; addr = 32'h20; data_in = 32'hFFFF_FFFF;
        en2 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; en2 = 1'b0;
        @(negedge clk);
        chk("abort_in_wait_busy", 32'(busy2), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done2) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_dout_reset", dout2, 32'd0);
        access(1, 1'b0, 1'b1, 32'h20, 32'h0, got);
        chk("abort_old_data", got, 32'hA5A5_A5A5);

        access(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, got);
        access(0, 1'b0, 1'b1, 32'h10, 32'h0, got);
        chk("w0_word_rd", got, 32'hDEAD_BEEF);

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 4; w++)
                access(d, 1'b1, 1'b1, 32'h40 + 32'(4*w), $urandom, got);
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra;
            ra = ($urandom & 32'hFFFF_FF00) | (32'h40 + 32'($urandom_range(0, 15)));
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ra, $urandom, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
